// File: rtl/serdes_sync_fifo.sv
// Single-clock FIFO between core logic and the output serializer, with standard or FWFT read mode.
// Define SERDES_SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module serdes_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    input  logic                    err_clr,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_acc, wr_acc;

    // Status flags come from the registered count only.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;

    always_comb begin
        rd_acc     = rd_en & ~empty;
        wr_acc     = wr_en & (~full | rd_acc);
        wr_ptr_d   = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d   = rd_ptr_q + AW'(rd_acc);
        count_d    = count_q + CW'(wr_acc) - CW'(rd_acc);
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_acc) begin
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // FWFT exposes the head entry directly so a pop costs no latency.
    assign rd_data  = (FWFT != 0) ? (empty ? '0 : mem[rd_ptr_q]) : rd_data_q;
    assign rd_valid = (FWFT != 0) ? ~empty : rd_valid_q;

`ifdef SERDES_SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        overflow_d  = (overflow_q & ~err_clr) | (wr_en & ~wr_acc);
        underflow_d = (underflow_q & ~err_clr) | (rd_en & empty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_serdes_sync_fifo.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and
// compares both against a queue-based model of the FIFO rules.
module tb_serdes_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int AEL   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en, rd_en, err_clr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae;
    logic [3:0]    s_count, f_count;
    logic          s_ovf, f_ovf, s_unf, f_unf;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_std_data;
    logic          exp_std_valid;
    logic          exp_ovf, exp_unf;

    always #5 clk = ~clk;

    serdes_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(0)) dut_std (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .err_clr(err_clr), .overflow(s_ovf), .underflow(s_unf)
    );

    serdes_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .err_clr(err_clr), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll();
        int n;
        n = q.size();
        checkOutput("std_count", 32'(s_count), 32'(n));
        checkOutput("fwft_count", 32'(f_count), 32'(n));
        checkOutput("empty", 32'({s_empty, f_empty}), {30'd0, {2{n == 0}}});
        checkOutput("full", 32'({s_full, f_full}), {30'd0, {2{n == DEPTH}}});
        checkOutput("almost_full", 32'({s_af, f_af}), {30'd0, {2{n >= AFL}}});
        checkOutput("almost_empty", 32'({s_ae, f_ae}), {30'd0, {2{n <= AEL}}});
        checkOutput("std_rd_valid", 32'(s_rd_valid), 32'(exp_std_valid));
        checkOutput("std_rd_data", 32'(s_rd_data), 32'(exp_std_data));
        checkOutput("fwft_rd_valid", 32'(f_rd_valid), 32'(n != 0));
        checkOutput("fwft_rd_data", 32'(f_rd_data), (n != 0) ? 32'(q[0]) : 32'd0);
        checkOutput("overflow", 32'({s_ovf, f_ovf}), {30'd0, {2{exp_ovf}}});
        checkOutput("underflow", 32'({s_unf, f_unf}), {30'd0, {2{exp_unf}}});
    endtask

    // One clock of stimulus; model updated from the FIFO rules, outputs checked 1 time unit after the edge.
    task automatic applyStimulus(input logic we, input logic [DW-1:0] wd, input logic re, input logic ec);
        bit was_empty, racc, wacc;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        err_clr = ec;
        @(posedge clk);
        was_empty = (q.size() == 0);
        racc = re && !was_empty;
        wacc = we && ((q.size() < DEPTH) || racc);
        exp_std_valid = racc;
        if (racc) exp_std_data = q.pop_front();
        if (wacc) q.push_back(wd);
`ifdef SERDES_SYNC_FIFO_ERR_FLAGS_EN
        exp_ovf = (exp_ovf && !ec) || (we && !wacc);
        exp_unf = (exp_unf && !ec) || (re && was_empty);
`else
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`endif
        #1;
        checkAll();
    endtask

    task automatic modelReset();
        q.delete();
        exp_std_data  = '0;
        exp_std_valid = 1'b0;
        exp_ovf       = 1'b0;
        exp_unf       = 1'b0;
    endtask

    initial begin
        int wp, rp;
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        wr_data = '0;
        modelReset();
        #12;
        checkAll();
        reset = 1'b0;

        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 9; i++) applyStimulus(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset with five entries held, checked before the next edge.
        #3;
        reset = 1'b1;
        modelReset();
        #1;
        checkAll();
        #2;
        reset = 1'b0;
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);

        for (int phase = 0; phase < 8; phase++) begin
            wp = (phase % 2 == 0) ? 80 : 30;
            rp = (phase % 2 == 0) ? 30 : 80;
            if (phase >= 6) begin
                wp = 60;
                rp = 60;
            end
            for (int i = 0; i < 60; i++) begin
                applyStimulus($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp,
                              $urandom_range(0, 15) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
